// File: rtl/poly_add_ctrl_pkg.sv
// Shared definitions for the polynomial coefficient-wise modular adder.
//   Q          : coefficient modulus
//   CoeffWidth : default coefficient width in bits
//   state_e    : controller FSM state encoding
package poly_add_ctrl_pkg;

  localparam int unsigned Q          = 3329;
  localparam int unsigned CoeffWidth = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/modular_add.sv
// Combinational modular adder: sum = (a + b) mod Q for a, b < Q.
//   a, b : operands, each below Q
//   sum  : reduced result, always below Q
module modular_add
  import poly_add_ctrl_pkg::*;
#(
  parameter int unsigned data_width = CoeffWidth
) (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic [data_width-1:0] sum
);

  localparam logic [data_width:0] QExt = (data_width + 1)'(Q);

  logic [data_width:0] raw;
  logic [data_width:0] reduced;

  // Both operands are below Q, so a single conditional subtract is enough.
  always_comb begin
    raw     = {1'b0, a} + {1'b0, b};
    reduced = raw - QExt;
    sum     = (raw >= QExt) ? reduced[data_width-1:0] : raw[data_width-1:0];
  end

endmodule

// File: rtl/poly_add_ctrl.sv
// Sequences C[i] = (A[i] + B[i]) mod Q over n_coeff coefficients held in
// synchronous-read RAM banks, through one shared combinational modular adder.
//   clk, rst           : clock, asynchronous active-high reset
//   start, pause       : run request (IDLE only), read-issue hold
//   rd_en, rd_addr     : shared read port to banks A and B (data next cycle)
//   a_rdata, b_rdata   : bank read data
//   wr_en, wr_addr,
//   wr_data            : bank C write port, two cycles after the read issue
//   busy, done         : run in progress, one-cycle completion pulse
module poly_add_ctrl
  import poly_add_ctrl_pkg::*;
#(
  parameter int unsigned data_width = CoeffWidth,
  parameter int unsigned addr_width = 8,
  parameter int unsigned n_coeff    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  output logic [addr_width-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [data_width-1:0] a_rdata,
  input  logic [data_width-1:0] b_rdata,
  output logic                  wr_en,
  output logic [addr_width-1:0] wr_addr,
  output logic [data_width-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [addr_width-1:0] LastAddr = addr_width'(n_coeff - 1);

  state_e                state_q;
  logic [addr_width-1:0] rd_cnt_q;
  logic                  s1_vld_q;
  logic [addr_width-1:0] s1_addr_q;
  logic                  wr_en_q;
  logic [addr_width-1:0] wr_addr_q;
  logic [data_width-1:0] wr_data_q;
  logic [data_width-1:0] sum;

  modular_add #(
    .data_width(data_width)
  ) u_modular_add (
    .a  (a_rdata),
    .b  (b_rdata),
    .sum(sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_cnt_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      // Stage 1: read data is on the bus while s1_vld_q is high.
      s1_vld_q <= rd_en;
      if (rd_en) begin
        s1_addr_q <= rd_cnt_q;
      end
      // Stage 2: write port holds its last values between writes.
      wr_en_q <= s1_vld_q;
      if (s1_vld_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= sum;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StRun;
            rd_cnt_q <= '0;
          end
        end
        StRun: begin
          if (!pause) begin
            // Hold at the last address rather than wrapping.
            if (rd_cnt_q == LastAddr) begin
              state_q <= StDrain;
            end else begin
              rd_cnt_q <= rd_cnt_q + addr_width'(1);
            end
          end
        end
        StDrain: begin
          // Once stage 1 is empty, the only op left is the stage-2 write
          // happening this cycle, so DONE lands one cycle after the last write.
          if (!s1_vld_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_en   = (state_q == StRun) && !pause;
  assign rd_addr = rd_cnt_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Scoreboard bench for poly_add_ctrl. Four instances with different n_coeff
// share one clock; each has its own RAM model, expected-write queue and monitor.
module tb_poly_add_ctrl;

  localparam int NI = 4;
  localparam int DW = 12;
  localparam int AW = 8;

  function automatic int nc_of(input int g);
    case (g)
      0:       return 4;
      1:       return 8;
      2:       return 1;
      default: return 256;
    endcase
  endfunction

  typedef struct {
    int addr;
    int data;
  } exp_t;

  typedef struct {
    int cyc;
    int addr;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst     [NI];
  logic          start   [NI];
  logic          pause   [NI];
  logic          rd_en   [NI];
  logic          wr_en   [NI];
  logic          busy    [NI];
  logic          done    [NI];
  logic [AW-1:0] rd_addr [NI];
  logic [AW-1:0] wr_addr [NI];
  logic [DW-1:0] wr_data [NI];

  int   mem_a  [NI][256];
  int   mem_b  [NI][256];
  exp_t exp_q  [NI][$];
  rd_t  rd_q   [NI][$];
  int   wr_cnt [NI];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [DW-1:0] a_rd;
    logic [DW-1:0] b_rd;
    exp_t          e;
    rd_t           r;

    poly_add_ctrl #(
      .data_width(DW),
      .addr_width(AW),
      .n_coeff   (nc_of(g))
    ) u_dut (
      .clk    (clk),
      .rst    (rst[g]),
      .start  (start[g]),
      .pause  (pause[g]),
      .rd_addr(rd_addr[g]),
      .rd_en  (rd_en[g]),
      .a_rdata(a_rd),
      .b_rdata(b_rd),
      .wr_en  (wr_en[g]),
      .wr_addr(wr_addr[g]),
      .wr_data(wr_data[g]),
      .busy   (busy[g]),
      .done   (done[g])
    );

    // Synchronous-read RAM banks A and B.
    always @(posedge clk) begin
      if (rd_en[g]) begin
        a_rd <= DW'(mem_a[g][rd_addr[g]]);
        b_rd <= DW'(mem_b[g][rd_addr[g]]);
      end
    end

    // Monitor: every write must match the next expected entry and land
    // exactly two cycles after the read of the same address.
    always @(negedge clk) begin
      if (!rst[g]) begin
        if (rd_en[g]) begin
          r.cyc  = cyc;
          r.addr = int'(rd_addr[g]);
          rd_q[g].push_back(r);
        end
        if (wr_en[g]) begin
          wr_cnt[g]++;
          if (rd_q[g].size() == 0) begin
            flag($sformatf("write_without_read inst%0d addr=%0d", g, wr_addr[g]));
          end else begin
            r = rd_q[g].pop_front();
            check($sformatf("write_latency inst%0d", g), cyc - r.cyc, 2);
            check($sformatf("write_vs_read_addr inst%0d", g), int'(wr_addr[g]), r.addr);
          end
          if (exp_q[g].size() == 0) begin
            flag($sformatf("unexpected_write inst%0d addr=%0d", g, wr_addr[g]));
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("wr_addr inst%0d", g), int'(wr_addr[g]), e.addr);
            check($sformatf("wr_data inst%0d addr%0d", g, e.addr), int'(wr_data[g]), e.data);
          end
        end
      end
    end
  end

  // Reference: C[i] = (A[i] + B[i]) mod 3329, written in address order.
  task automatic push_exp(input int g);
    exp_t e;
    exp_q[g].delete();
    for (int i = 0; i < nc_of(g); i++) begin
      e.addr = i;
      e.data = (mem_a[g][i] + mem_b[g][i]) % 3329;
      exp_q[g].push_back(e);
    end
  endtask

  task automatic fill_random(input int g);
    for (int i = 0; i < nc_of(g); i++) begin
      mem_a[g][i] = int'($urandom_range(0, 3328));
      mem_b[g][i] = int'($urandom_range(0, 3328));
    end
  endtask

  task automatic start_run(input int g, output int c0);
    @(negedge clk);
    start[g] = 1'b1;
    c0       = cyc;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int limit, output int dc);
    dc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done[g]) begin
        dc = cyc;
        return;
      end
    end
    flag($sformatf("done_timeout inst%0d", g));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, dc, w0, wp, rp, nr;

    for (int g = 0; g < NI; g++) begin
      rst[g]    = 1'b1;
      start[g]  = 1'b0;
      pause[g]  = 1'b0;
      wr_cnt[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("reset rd_en inst%0d", g), int'(rd_en[g]), 0);
      check($sformatf("reset rd_addr inst%0d", g), int'(rd_addr[g]), 0);
      check($sformatf("reset wr_en inst%0d", g), int'(wr_en[g]), 0);
      check($sformatf("reset wr_addr inst%0d", g), int'(wr_addr[g]), 0);
      check($sformatf("reset wr_data inst%0d", g), int'(wr_data[g]), 0);
      check($sformatf("reset busy inst%0d", g), int'(busy[g]), 0);
      check($sformatf("reset done inst%0d", g), int'(done[g]), 0);
    end
    for (int g = 0; g < NI; g++) rst[g] = 1'b0;
    repeat (2) @(negedge clk);

    // Normal run, n_coeff = 4, fixed vectors.
    mem_a[0][0] = 100;  mem_a[0][1] = 2000; mem_a[0][2] = 3328; mem_a[0][3] = 1664;
    mem_b[0][0] = 200;  mem_b[0][1] = 2000; mem_b[0][2] = 1;    mem_b[0][3] = 1665;
    push_exp(0);
    w0 = wr_cnt[0];
    start_run(0, c0);
    check("normal busy_after_start", int'(busy[0]), 1);
    wait_done(0, 50, dc);
    check("normal done_cycle", dc - c0, 7);
    check("normal busy_at_done", int'(busy[0]), 1);
    check("normal write_count", wr_cnt[0] - w0, 4);
    @(negedge clk);
    check("normal busy_after_done", int'(busy[0]), 0);
    check("normal done_pulse_width", int'(done[0]), 0);

    // Ignored start: pulse in RUN and again in the DONE cycle.
    push_exp(0);
    w0 = wr_cnt[0];
    start_run(0, c0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 50, dc);
    check("ignstart done_cycle", dc - c0, 7);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("ignstart busy_after_done", int'(busy[0]), 0);
    repeat (6) @(negedge clk);
    check("ignstart busy_stays_low", int'(busy[0]), 0);
    check("ignstart write_count", wr_cnt[0] - w0, 4);

    // Pause for 3 cycles after the third read, n_coeff = 8.
    fill_random(1);
    push_exp(1);
    w0 = wr_cnt[1];
    start_run(1, c0);
    nr = rd_en[1] ? 1 : 0;
    for (int i = 0; i < 20 && nr < 3; i++) begin
      @(negedge clk);
      if (rd_en[1]) nr++;
    end
    check("pause third_read_cycle", cyc - c0, 3);
    wp = 0;
    rp = 0;
    @(posedge clk);
    #1 pause[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      wp += int'(wr_en[1]);
      rp += int'(rd_en[1]);
      @(posedge clk);
    end
    #1 pause[1] = 1'b0;
    check("pause reads_during_pause", rp, 0);
    check("pause writes_during_pause", wp, 2);
    wait_done(1, 50, dc);
    check("pause done_cycle", dc - c0, 14);
    check("pause write_count", wr_cnt[1] - w0, 8);

    // Asynchronous reset after the second read of 8.
    fill_random(1);
    push_exp(1);
    w0 = wr_cnt[1];
    start_run(1, c0);
    @(negedge clk);
    #2 rst[1] = 1'b1;
    #1;
    check("rstmid wr_en", int'(wr_en[1]), 0);
    check("rstmid busy", int'(busy[1]), 0);
    check("rstmid done", int'(done[1]), 0);
    check("rstmid rd_en", int'(rd_en[1]), 0);
    exp_q[1].delete();
    rd_q[1].delete();
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);
    check("rstmid no_writes_after_reset", wr_cnt[1] - w0, 0);
    check("rstmid busy_stays_low", int'(busy[1]), 0);
    fill_random(1);
    push_exp(1);
    w0 = wr_cnt[1];
    start_run(1, c0);
    check("rstmid restart_addr", int'(rd_addr[1]), 0);
    wait_done(1, 50, dc);
    check("rstmid restart_done_cycle", dc - c0, 11);
    check("rstmid restart_write_count", wr_cnt[1] - w0, 8);

    // n_coeff = 1, maximal operands.
    mem_a[2][0] = 3328;
    mem_b[2][0] = 3328;
    push_exp(2);
    w0 = wr_cnt[2];
    start_run(2, c0);
    wait_done(2, 20, dc);
    check("single done_cycle", dc - c0, 4);
    check("single write_count", wr_cnt[2] - w0, 1);

    // 256 random coefficients with random pause bubbles.
    fill_random(3);
    push_exp(3);
    w0 = wr_cnt[3];
    start_run(3, c0);
    dc = -1;
    for (int i = 0; i < 3000 && dc < 0; i++) begin
      @(posedge clk);
      #1 pause[3] = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (done[3]) dc = cyc;
    end
    pause[3] = 1'b0;
    if (dc < 0) flag("random done_timeout");
    check("random write_count", wr_cnt[3] - w0, 256);

    repeat (4) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("final exp_queue_empty inst%0d", g), exp_q[g].size(), 0);
      check($sformatf("final read_queue_empty inst%0d", g), rd_q[g].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
